alu_arbiter: RTL and testbench

Shares one combinational 4-bit ALU (ops: add, sub, and, or, not-a) between NUM_REQ requesters. Each requester issues an {a, b, sel} operation over a valid/ready handshake. A round-robin grant selects one requester, drives the ALU operands for one cycle, and registers the result. The result is returned on a shared response channel tagged with the requester id. The block sits between the requesting engines and the ALU instance.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, width and FSM state definitions for alu_arbiter
//
// Purpose: common definitions imported by the arbiter interface, rr_arbiter and
// alu_arbiter top. No ports.
//   OPC_W          opcode width
//   OP_ADD..OP_NOT opcodes understood by the shared ALU (101-111 yield 0)
//   state_t        arbiter FSM states
package alu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPC_W-1:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bus between requesters and alu_arbiter
//
// Purpose: bundles the per-requester request channel and the shared response channel.
//   req_valid/req_ready  per-requester handshake (NUM_REQ bits each)
//   req_a/req_b          operands, requester i at [i*WIDTH +: WIDTH]
//   req_sel              opcodes, requester i at [i*OPC_W +: OPC_W]
//   rsp_valid/rsp_ready  shared response handshake
//   rsp_id/rsp_y         owner index and result
// Modports: slave = arbiter side, master = requester/consumer side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 1
);
  import alu_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*OPC_W-1:0] req_sel;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_y;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot grant selection for alu_arbiter
//
// Purpose: picks one requester from req. Default build searches upward from ptr
// with wrap-around; with ALU_ARB_FIXED_PRIO_EN defined the lowest index wins and
// ptr is ignored.
//   req    in   NUM_REQ  request vector
//   ptr    in   ID_W     round-robin start index (always < NUM_REQ)
//   grant  out  NUM_REQ  one-hot grant, zero when req is zero
//   id     out  ID_W     encoded index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Walk downward so the lowest set index is the last (winning) assignment.
  always_comb begin
    grant = '0;
    id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        id       = ID_W'(i);
      end
    end
  end
`else
  logic found;

  // Step k covers index (ptr + k) mod NUM_REQ; both loops are constant-bounded so
  // every select into req is a static index.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_REQ))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          id       = ID_W'(i);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU among NUM_REQ requesters
//
// Purpose: grants one request at a time, presents its operands to the external ALU
// for one cycle, registers the result and returns it tagged with the requester id.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed lowest-index priority, no rr pointer).
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   bus      slave       alu_arbiter_if request/response channels
//   alu_a    out  WIDTH  ALU operand a (from latched operand register)
//   alu_b    out  WIDTH  ALU operand b
//   alu_sel  out  3      ALU opcode
//   alu_y    in   WIDTH  ALU result (combinational)
//   busy     out  1      high whenever the FSM is not IDLE
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OPC_W-1:0]  alu_sel,
  input  logic [WIDTH-1:0]  alu_y,
  output logic              busy
);

  state_t              state;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [OPC_W-1:0]    op_sel;
  logic [ID_W-1:0]     op_id;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [WIDTH-1:0]    rsp_y_q;
  logic                busy_q;
  logic [ID_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_id;
  logic [WIDTH-1:0]    gnt_a;
  logic [WIDTH-1:0]    gnt_b;
  logic [OPC_W-1:0]    gnt_sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .id    (gnt_id)
  );

  // Operand mux for the granted requester; grant is one-hot so at most one hit.
  always_comb begin
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_a   = bus.req_a[i*WIDTH +: WIDTH];
        gnt_b   = bus.req_b[i*WIDTH +: WIDTH];
        gnt_sel = bus.req_sel[i*OPC_W +: OPC_W];
      end
    end
  end

  // Grant is only offered in IDLE; rst gates it so reset reads as "no accept"
  // even while requests are pending.
  assign bus.req_ready = (state == ST_IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_sel      <= '0;
      op_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      busy_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_a   <= gnt_a;
            op_b   <= gnt_b;
            op_sel <= gnt_sel;
            op_id  <= gnt_id;
            busy_q <= 1'b1;
            state  <= ST_EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
          end
        end
        ST_EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_id_q    <= op_id;
          rsp_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a         = op_a;
  assign alu_b         = op_b;
  assign alu_sel       = op_sel;
  assign busy          = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 4;
  localparam int ID_W    = 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic             busy;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_y   (alu_y),
    .busy    (busy)
  );

  // Stand-in for the external combinational ALU.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = ~alu_a;
      default: alu_y = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int fails  = 0;
  int rr_next = 0;
  int ra[NUM_REQ];
  int rb[NUM_REQ];
  int rs[NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_y(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      3:       return a | b;
      4:       return 15 - a;
      default: return 0;
    endcase
  endfunction

  function automatic int pick(input logic [1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (rr_next + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b, input int s);
    ra[i] = a;
    rb[i] = b;
    rs[i] = s;
    bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    bus.req_sel[i*3 +: 3]       = 3'(s);
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic issue(input logic [1:0] vmask, input int hold);
    int w;
    int ey;
    w = pick(vmask);
    bus.req_valid = vmask;
    #1;
    check("req_ready_idle", 32'(bus.req_ready), 32'(1 << w));
    @(posedge clk);
    @(negedge clk);
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_next = (w + 1) % NUM_REQ;
`endif
    bus.req_valid[w] = 1'b0;
    ey = ref_y(ra[w], rb[w], rs[w]);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_req_ready", 32'(bus.req_ready), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'(ra[w]));
    check("exec_alu_b", 32'(alu_b), 32'(rb[w]));
    check("exec_alu_sel", 32'(alu_sel), 32'(rs[w]));
    bus.rsp_ready = (hold == 0);
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_y", 32'(bus.rsp_y), 32'(ey));
    check("rsp_id", 32'(bus.rsp_id), 32'(w));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_y", 32'(bus.rsp_y), 32'(ey));
      check("hold_rsp_id", 32'(bus.rsp_id), 32'(w));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset, then repeated simultaneous requests.
    set_op(0, 9, 3, 1);
    set_op(1, 12, 10, 2);
    for (int n = 0; n < 4; n++) issue(2'b11, 0);

    // Single add, backpressure, wrap, invalid opcode, NOT.
    set_op(0, 3, 5, 0);
    issue(2'b01, 0);
    set_op(1, 12, 10, 3);
    issue(2'b10, 5);
    set_op(0, 15, 1, 0);
    issue(2'b01, 0);
    set_op(1, 15, 0, 5);
    issue(2'b10, 0);
    set_op(0, 10, 0, 4);
    issue(2'b01, 0);

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      for (int i = 0; i < NUM_REQ; i++)
        set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 7)));
      issue(m, int'($urandom_range(0, 2)));
    end
    bus.req_valid = '0;

    // Reset mid-EXEC: leave the pointer away from 0 first.
    set_op(0, 1, 2, 0);
    issue(2'b01, 0);
    set_op(0, 5, 6, 0);
    set_op(1, 7, 1, 0);
    w = pick(2'b11);
    bus.req_valid = 2'b11;
    #1;
    check("pre_rst_req_ready", 32'(bus.req_ready), 32'(1 << w));
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    rr_next = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    issue(2'b11, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
